// File: rtl/mac_accumulator_32b.sv
// mac_accumulator_32b: multiply-accumulate sequencer summing N_TERMS products from an external multiplier.
// Optional feature: define MAC_SATURATE_EN to saturate the accumulator on overflow instead of wrapping.
module mac_accumulator_32b #(
    parameter int SIZE    = 32,
    parameter int N_TERMS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE-1:0]     A,
    input  logic [31:0]         B,
    output logic [SIZE-1:0]     op_A,
    output logic [31:0]         op_B,
    input  logic [2*SIZE-1:0]   prod,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*SIZE-1:0]   result,
    output logic                ovf
);
`ifdef MAC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, CAPT, ACC, DONE} state_t;
    state_t              state;
    logic [2*SIZE-1:0]   acc;
    logic [2*SIZE-1:0]   prod_r;
    logic [7:0]          count;
    logic [2*SIZE:0]     sum;
    assign sum    = {1'b0, acc} + {1'b0, prod_r};
    assign result = acc;
    // Sequencer: accept operands, let the multiplier settle one cycle, accumulate, hand off the result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            acc       <= '0;
            prod_r    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            op_A      <= '0;
            op_B      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            acc       <= '0;
            prod_r    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_A     <= A;
                    op_B     <= B;
                    state    <= CAPT;
                    in_ready <= 1'b0;
                end
                CAPT: begin
                    prod_r <= prod;
                    state  <= ACC;
                end
                ACC: begin
                    acc   <= (SAT && sum[2*SIZE]) ? '1 : sum[2*SIZE-1:0];
                    ovf   <= ovf | sum[2*SIZE];
                    count <= count + 8'd1;
                    if (count == 8'(N_TERMS - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    acc       <= '0;
                    count     <= '0;
                    ovf       <= 1'b0;
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_accumulator_32b.sv
// tb_mac_accumulator_32b: directed and random checks of mac_accumulator_32b against an arithmetic sum model.
module tb_mac_accumulator_32b;
    localparam int SIZE = 32;
`ifdef MAC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    logic              clk = 1'b0, reset = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [SIZE-1:0]   A = '0;
    logic [31:0]       B = '0;
    logic              in_ready, out_valid, ovf;
    logic [SIZE-1:0]   op_A;
    logic [31:0]       op_B;
    logic [2*SIZE-1:0] prod, result;
    int                n_assert = 0, n_fail = 0, cyc = 0, last_acc = 0, c0 = 0;
    logic [127:0]      total = '0;
    logic [31:0]       la, lb;

    mac_accumulator_32b #(.SIZE(SIZE), .N_TERMS(4)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op_A(op_A), .op_B(op_B), .prod(prod), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .ovf(ovf)
    );

    // ideal multiplier
    assign prod = 64'(op_A) * 64'(op_B);

    always #5 clk = ~clk;

    // model: true mathematical sum of all products of the current result
    function automatic logic [63:0] exp_result();
        return (SAT && total[127:64] != 0) ? 64'hFFFF_FFFF_FFFF_FFFF : total[63:0];
    endfunction

    function automatic logic exp_ovf();
        return total[127:64] != 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic term(input logic [31:0] a, input logic [31:0] b);
        int w = 0;
        while (!in_ready && w < 20) begin tick(); w++; end
        chk("ready_wait", in_ready, 1);
        A = a; B = b; in_valid = 1'b1;
        tick();
        last_acc = cyc;
        in_valid = 1'b0; A = $urandom; B = $urandom;
        chk("op_A", op_A, a);
        chk("op_B", op_B, b);
        chk("busy", in_ready, 0);
        total += 128'(a) * 128'(b);
    endtask

    task automatic wait_done(input string tag);
        int w = 0;
        while (!out_valid && w < 20) begin tick(); w++; end
        chk({tag, "_lat"}, 64'(cyc - last_acc), 2);
        chk({tag, "_result"}, result, exp_result());
        chk({tag, "_ovf"}, ovf, exp_ovf());
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("rel_result", result, 0);
        chk("rel_valid", out_valid, 0);
        chk("rel_ovf", ovf, 0);
        chk("rel_ready", in_ready, 1);
        total = '0;
    endtask

    initial begin
        #12;
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_opA", op_A, 0);
        @(negedge clk) reset = 1'b1;
        tick();
        chk("rst_rel_ready", in_ready, 1);

        // basic sum with exact end-to-end latency
        term(3, 5);
        c0 = last_acc;
        term(7, 2);
        term(10, 10);
        term(1, 1);
        wait_done("basic");
        chk("basic_130", result, 130);
        chk("basic_lat12", 64'(cyc - c0 + 1), 12);

        // backpressure with ignored inputs
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; A = $urandom; B = $urandom;
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_result", result, 130);
            chk("bp_ready", in_ready, 0);
            chk("bp_opA", op_A, 1);
        end
        in_valid = 1'b0;
        release_result();

        // overflow
        for (int i = 0; i < 4; i++) term(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("ovf");
        chk("ovf_flag", ovf, 1);
        chk("ovf_const", result, SAT ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFF8_0000_0004);
        release_result();

        // random rounds, some with large operands
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++)
                term(r[0] ? ($urandom | 32'hC000_0000) : $urandom_range(0, 65535), $urandom);
            wait_done("rand");
            release_result();
        end

        // clear colliding with in_valid after two terms
        term(11, 12);
        term(13, 14);
        for (int w = 0; w < 5 && !in_ready; w++) tick();
        clear = 1'b1; in_valid = 1'b1; A = 99; B = 99;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        total = '0;
        chk("clr_ready", in_ready, 1);
        chk("clr_result", result, 0);
        chk("clr_opA", op_A, 13);
        chk("clr_ovf", ovf, 0);
        for (int i = 0; i < 4; i++) term($urandom, $urandom);
        wait_done("clr_fresh");
        release_result();

        // reset during CAPT discards partial sum
        term(5, 6);
        term(7, 8);
        term(9, 10);
        reset = 1'b0;
        #2;
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_opA", op_A, 0);
        chk("mid_rst_opB", op_B, 0);
        @(negedge clk) reset = 1'b1;
        tick();
        chk("mid_rst_rel", in_ready, 1);
        total = '0;
        for (int i = 0; i < 4; i++) term($urandom, $urandom);
        wait_done("post_rst");
        release_result();

        // continuous in_valid: accepts every 3 cycles
        in_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            A = $urandom; B = $urandom;
            if (k % 3 == 0) begin
                la = A; lb = B;
                total += 128'(la) * 128'(lb);
            end
            tick();
            chk("thr_opA", op_A, la);
            chk("thr_opB", op_B, lb);
        end
        in_valid = 1'b0;
        chk("thr_valid", out_valid, 1);
        chk("thr_result", result, exp_result());
        chk("thr_ovf", ovf, exp_ovf());
        release_result();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
